// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit with architectural HI/LO.
// A shift-add multiplier and a restoring divider share one 64-bit accumulator.
// Each operation takes 32 iteration cycles plus one sign-fix cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] acc;         // product, or remainder in the upper half
    logic [31:0] mq;          // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [31:0] dvs;         // multiplicand or divisor magnitude
    logic        is_div_r;
    logic        neg_res_r;   // operand signs differ on a signed op
    logic        neg_a_r;     // dividend negative on a signed op
    logic        div_zero_r;

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic               is_signed_op;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [32:0]        mul_sum;
    logic [32:0]        div_rem_sh;
    logic [32:0]        div_trial;
    logic               div_ok;
    logic [63:0]        prod;
    logic [31:0]        fix_hi;
    logic [31:0]        fix_lo;

    // Two's-complement negation when en is set; 0x80000000 maps to itself,
    // which read as unsigned is the magnitude 2^31.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        logic signed [31:0] sv;
        sv = v;
        return en ? -sv : sv;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
        logic signed [63:0] sv;
        sv = v;
        return en ? -sv : sv;
    endfunction

    assign busy = (state != IDLE);

    // Operand decode: magnitudes and sign flags for the operation being launched.
    always_comb begin
        a_s          = A;
        b_s          = B;
        is_signed_op = ~op[0];
        a_neg        = is_signed_op && (a_s < 0);
        b_neg        = is_signed_op && (b_s < 0);
        a_mag        = cond_neg32(A, a_neg);
        b_mag        = cond_neg32(B, b_neg);
    end

    // One iteration step: 33-bit add for multiply, 33-bit trial subtract for divide.
    // The remainder before shifting is below the divisor, so a non-negative trial
    // always fits in 32 bits and bit 32 acts as the borrow.
    always_comb begin
        mul_sum    = {1'b0, acc[63:32]} + {1'b0, (mq[0] ? dvs : 32'd0)};
        div_rem_sh = {acc[63:32], mq[31]};
        div_trial  = div_rem_sh - {1'b0, dvs};
        div_ok     = ~div_trial[32];
    end

    // Sign correction of the finished magnitudes; divide-by-zero forces LO to all ones
    // while HI naturally returns the original dividend.
    always_comb begin
        prod = cond_neg64(acc, neg_res_r);
        if (is_div_r) begin
            fix_hi = cond_neg32(acc[63:32], neg_a_r);
            fix_lo = div_zero_r ? 32'hFFFF_FFFF : cond_neg32(mq, neg_res_r);
        end else begin
            fix_hi = prod[63:32];
            fix_lo = prod[31:0];
        end
    end

    // Datapath: load operands on accept, then one shift-add or shift-subtract per RUN cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc        <= '0;
            mq         <= op[1] ? a_mag : b_mag;
            dvs        <= op[1] ? b_mag : a_mag;
            is_div_r   <= op[1];
            neg_res_r  <= a_neg ^ b_neg;
            neg_a_r    <= a_neg;
            div_zero_r <= (B == 32'd0);
        end else if (state == RUN) begin
            if (is_div_r) begin
                acc[63:32] <= div_ok ? div_trial[31:0] : div_rem_sh[31:0];
                mq         <= {mq[30:0], div_ok};
            end else begin
                acc <= {mul_sum, acc[31:1]};
                mq  <= {1'b0, mq[31:1]};
            end
        end
    end

    // Control FSM with HI/LO: MTHI/MTLO only in IDLE, result written in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) HI <= wdata;
                    if (lo_we) LO <= wdata;
                    if (start) begin
                        state <= RUN;
                        cnt   <= 6'd0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= FIX;
                end
                FIX: begin
                    HI    <= fix_hi;
                    LO    <= fix_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: arithmetic reference model plus per-cycle comparison,
// directed scenarios and randomized operations.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: full-width integer math, truncating division.
    function automatic void calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        case (o)
            2'd0: begin r = sa * sb; hi = r[63:32]; lo = r[31:0]; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; hi = u[63:32]; lo = u[31:0]; end
            2'd2: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin r = sa / sb; lo = r[31:0]; r = sa % sb; hi = r[31:0]; end
            end
            default: begin
                if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                else begin lo = a / b; hi = a % b; end
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the handshake: a result lands 33 edges after the accept edge.
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          m_fin = 0;
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_res_hi = 32'd0;
    logic [31:0] m_res_lo = 32'd0;

    always @(posedge clk) begin
        logic [31:0] rh;
        logic [31:0] rl;
        cyc    <= cyc + 1;
        m_done <= 1'b0;
        if (reset) begin
            m_active <= 1'b0;
            m_hi     <= 32'd0;
            m_lo     <= 32'd0;
            chk_en   <= 1'b1;
        end else if (m_active) begin
            if (cyc == m_fin) begin
                m_hi     <= m_res_hi;
                m_lo     <= m_res_lo;
                m_done   <= 1'b1;
                m_active <= 1'b0;
            end
        end else begin
            if (hi_we) m_hi <= wdata;
            if (lo_we) m_lo <= wdata;
            if (start) begin
                calc(op, A, B, rh, rl);
                m_res_hi <= rh;
                m_res_lo <= rl;
                m_fin    <= cyc + 33;
                m_active <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_track", {31'd0, busy}, {31'd0, m_active});
            chk("done_track", {31'd0, done}, {31'd0, m_done});
            chk("hi_track", HI, m_hi);
            chk("lo_track", LO, m_lo);
        end
    end

    // Called just after a negedge with the unit idle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, output int n);
        n = already;
        while (!done && n < 45) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(n), 32'd33);
    endtask

    task automatic directed(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue(o, a, b);
        wait_done(0, n);
        chk({name, "_latency"}, 32'(n), 32'd33);
        chk({name, "_hi"}, HI, eh);
        chk({name, "_lo"}, LO, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_random_op();
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          n;
        o = 2'($urandom_range(0, 3));
        a = pick();
        b = pick();
        calc(o, a, b, eh, el);
        issue(o, a, b);
        n = 0;
        while (!done && n < 45) begin
            start = ($urandom_range(0, 7) == 0);
            hi_we = ($urandom_range(0, 7) == 0);
            lo_we = ($urandom_range(0, 7) == 0);
            wdata = $urandom;
            op    = 2'($urandom_range(0, 3));
            A     = $urandom;
            B     = $urandom;
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("rand_latency", 32'(n), 32'd33);
        chk("rand_hi", HI, eh);
        chk("rand_lo", LO, el);
        if ($urandom_range(0, 3) == 0) begin
            hi_we = 1'b1; wdata = $urandom;
            @(posedge clk);
            @(negedge clk);
            hi_we = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] th;
        logic [31:0] tl;
        int          n;
        int          dcount;

        // Model pinned against hand-computed values.
        calc(2'd0, 32'hFFFF_FFFD, 32'd5, th, tl);
        chk("model_mult_hi", th, 32'hFFFF_FFFF);
        chk("model_mult_lo", tl, 32'hFFFF_FFF1);
        calc(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, th, tl);
        chk("model_multu_hi", th, 32'hFFFF_FFFE);
        chk("model_multu_lo", tl, 32'h0000_0001);
        calc(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, th, tl);
        chk("model_divmin_hi", th, 32'h0000_0000);
        chk("model_divmin_lo", tl, 32'h8000_0000);

        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        directed("mult", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        directed("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        directed("divu_zero", 2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        directed("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        directed("div_min", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        directed("div_zero_neg", 2'd2, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        directed("div_posneg", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        // MTHI / MTLO while idle.
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_idle", HI, 32'h1234_5678);
        lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        @(posedge clk); @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", LO, 32'h9ABC_DEF0);

        // MTHI / MTLO while busy are dropped.
        issue(2'd3, 32'd100, 32'd7);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        @(posedge clk); @(negedge clk);
        lo_we = 1'b0;
        wait_done(5, n);
        chk("busy_write_latency", 32'(n), 32'd33);
        chk("busy_write_hi", HI, 32'd2);
        chk("busy_write_lo", LO, 32'd14);

        // start mid-run with new operands is ignored.
        issue(2'd1, 32'd6, 32'd7);
        repeat (5) begin @(posedge clk); @(negedge clk); end
        op = 2'd2; A = 32'd100; B = 32'd3; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(6, n);
        chk("midrun_latency", 32'(n), 32'd33);
        chk("midrun_hi", HI, 32'd0);
        chk("midrun_lo", LO, 32'd42);

        // start in the done cycle launches back-to-back.
        issue(2'd0, 32'd9, 32'hFFFF_FFFE);
        wait_done(0, n);
        chk("b2b_first_lo", LO, 32'hFFFF_FFEE);
        issue(2'd3, 32'd50, 32'd8);
        wait_done(0, n);
        chk("b2b_gap", 32'(n + 1), 32'd34);
        chk("b2b_hi", HI, 32'd2);
        chk("b2b_lo", LO, 32'd6);

        // Reset during RUN iteration 10 discards the operation.
        issue(2'd1, 32'd1234, 32'd5678);
        repeat (10) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_hi", HI, 32'd0);
        chk("midreset_lo", LO, 32'd0);
        reset = 1'b0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (done) dcount++;
        end
        chk("midreset_no_done", 32'(dcount), 32'd0);
        directed("after_reset", 2'd1, 32'd1234, 32'd5678, 32'd0, 32'd7006652);

        for (int i = 0; i < 60; i++) run_random_op();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
